shift_reg_seq_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4-bit universal shift register and drives its mode-select, parallel-input and serial-input pins. It accepts a parallel word over a start/ready handshake and commands a one-cycle parallel load. It then commands WIDTH shift cycles in the chosen direction and presents the bit leaving the register as a framed serial stream. It reads the register's parallel output back to produce that stream.

---
 rtl/shift_reg_seq_ctrl.sv | 106 ++++++++++
 tb/tb_shift_reg_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer for a universal shift register: loads a parallel word and then
// commands WIDTH shifts, presenting the bit leaving the register as a framed serial stream.
module shift_reg_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  input  logic             dir,
  input  logic             fill,
  input  logic             abort,
  input  logic [WIDTH-1:0] A_par,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] I_par,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic             ready,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  if (((2 ** CNT_W) <= WIDTH) || (WIDTH < 2)) begin : g_bad_params
    $error("shift_reg_seq_ctrl: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TAP_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] TAP_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  // One-hot tap on the readback word: bit 0 for right shifts, MSB for left shifts.
  logic [WIDTH-1:0] tap_q;

  assign ser_out = |(A_par & tap_q);

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tap_q     <= TAP_LSB;
      s1        <= 1'b0;
      s0        <= 1'b0;
      I_par     <= '0;
      MSB_in    <= 1'b0;
      LSB_in    <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state_q == LOAD || state_q == SHIFT)) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      {s1, s0}  <= 2'b00;
      ready     <= 1'b1;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD;
            I_par    <= word;
            tap_q    <= dir ? TAP_MSB : TAP_LSB;
            MSB_in   <= fill & ~dir;
            LSB_in   <= fill & dir;
            {s1, s0} <= 2'b11;
            ready    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state_q   <= SHIFT;
          cnt_q     <= '0;
          {s1, s0}  <= tap_q[WIDTH-1] ? 2'b10 : 2'b01;
          ser_valid <= 1'b1;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            {s1, s0}  <= 2'b00;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Directed bench for shift_reg_seq_ctrl with a behavioural 4-bit universal shift register attached.
module tb_shift_reg_seq_ctrl;

  logic       CLK = 1'b0;
  logic       Clear, start, dir, fill, abort;
  logic [3:0] word;
  logic [3:0] A_par = 4'b0000;
  logic       s1, s0, MSB_in, LSB_in, ready, busy, ser_out, ser_valid, done;
  logic [3:0] I_par;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  shift_reg_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK(CLK), .Clear(Clear), .start(start), .word(word), .dir(dir), .fill(fill),
    .abort(abort), .A_par(A_par), .s1(s1), .s0(s0), .I_par(I_par), .MSB_in(MSB_in),
    .LSB_in(LSB_in), .ready(ready), .busy(busy), .ser_out(ser_out),
    .ser_valid(ser_valid), .done(done)
  );

  always #5 CLK = ~CLK;

  // Behavioural universal shift register driven by the sequencer.
  always @(posedge CLK) begin
    case ({s1, s0})
      2'b11:   A_par <= I_par;
      2'b01:   A_par <= {MSB_in, A_par[3:1]};
      2'b10:   A_par <= {A_par[2:0], LSB_in};
      default: A_par <= A_par;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " s1s0"}, {s1, s0}, 2'b00);
    chk({tag, " ready"}, ready, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " ser_valid"}, ser_valid, 1'b0);
    chk({tag, " done"}, done, 1'b0);
  endtask

  // Accepts a word on the next edge, then checks the LOAD cycle.
  task automatic launch(input string tag, input logic [3:0] w, input logic d, input logic f);
    word = w; dir = d; fill = f; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " load s1s0"}, {s1, s0}, 2'b11);
    chk({tag, " load I_par"}, I_par, w);
    chk({tag, " load MSB_in"}, MSB_in, f & ~d);
    chk({tag, " load LSB_in"}, LSB_in, f & d);
    chk({tag, " load ready"}, ready, 1'b0);
    chk({tag, " load busy"}, busy, 1'b1);
  endtask

  // seq lists the emitted bits in order, first bit in seq[3].
  task automatic shift_phase(input string tag, input logic [1:0] s_exp, input logic [3:0] seq);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s k%0d s1s0", tag, k), {s1, s0}, s_exp);
      chk($sformatf("%s k%0d ser_valid", tag, k), ser_valid, 1'b1);
      chk($sformatf("%s k%0d ser_out", tag, k), ser_out, seq[3-k]);
      chk($sformatf("%s k%0d done", tag, k), done, 1'b0);
      chk($sformatf("%s k%0d ready", tag, k), ready, 1'b0);
    end
  endtask

  task automatic done_phase(input string tag, input logic [3:0] a_exp);
    tick();
    chk({tag, " done pulse"}, done, 1'b1);
    chk({tag, " done s1s0"}, {s1, s0}, 2'b00);
    chk({tag, " done ser_valid"}, ser_valid, 1'b0);
    chk({tag, " done ready"}, ready, 1'b0);
    chk({tag, " A_par after"}, A_par, a_exp);
    tick();
    idle_outputs({tag, " idle"});
  endtask

  initial begin
    int dn;
    int gap;
    Clear = 1'b1; start = 1'b0; word = 4'h0; dir = 1'b0; fill = 1'b0; abort = 1'b0;
    tick();
    tick();
    idle_outputs("reset");
    chk("reset I_par", I_par, 4'h0);
    chk("reset MSB_in", MSB_in, 1'b0);
    chk("reset LSB_in", LSB_in, 1'b0);
    Clear = 1'b0;
    tick();

    // Clear asserted in SHIFT cycle k=1 of word 1010.
    launch("clr", 4'b1010, 1'b0, 1'b0);
    tick();
    tick();
    chk("clr pre ser_valid", ser_valid, 1'b1);
    Clear = 1'b1;
    #1;
    idle_outputs("clr async");
    tick();
    Clear = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dn++;
    end
    chk("clr no done pulse", dn, 0);
    idle_outputs("clr after");

    // Right transfer: 1011, fill 1.
    launch("right", 4'b1011, 1'b0, 1'b1);
    shift_phase("right", 2'b01, 4'b1101);
    done_phase("right", 4'b1111);

    // Left transfer: 1010, fill 0.
    launch("left", 4'b1010, 1'b1, 1'b0);
    shift_phase("left", 2'b10, 4'b1010);
    done_phase("left", 4'b0000);

    // Start pulsed with 0110 during SHIFT of 0011 must be ignored.
    launch("busy", 4'b0011, 1'b0, 1'b0);
    tick();
    chk("busy k0 ser_out", ser_out, 1'b1);
    start = 1'b1; word = 4'b0110;
    tick();
    start = 1'b0;
    chk("busy k1 ser_out", ser_out, 1'b1);
    chk("busy k1 s1s0", {s1, s0}, 2'b01);
    chk("busy k1 ready", ready, 1'b0);
    tick();
    chk("busy k2 ser_out", ser_out, 1'b0);
    chk("busy k2 s1s0", {s1, s0}, 2'b01);
    chk("busy k2 I_par", I_par, 4'b0011);
    tick();
    chk("busy k3 ser_out", ser_out, 1'b0);
    chk("busy k3 ready", ready, 1'b0);
    done_phase("busy", 4'b0000);
    tick();
    chk("busy stays idle", busy, 1'b0);

    // Abort in SHIFT k=1 of 1100, then a normal left transfer of 0101.
    launch("abort", 4'b1100, 1'b0, 1'b0);
    tick();
    chk("abort k0 ser_out", ser_out, 1'b0);
    tick();
    chk("abort k1 ser_out", ser_out, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_outputs("abort next");
    chk("abort A_par", A_par, 4'b0011);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dn++;
    end
    chk("abort no done", dn, 0);
    chk("abort A_par held", A_par, 4'b0011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort ignored idle", ready, 1'b1);
    launch("restart", 4'b0101, 1'b1, 1'b1);
    shift_phase("restart", 2'b10, 4'b0101);
    done_phase("restart", 4'b1111);

    // Back-to-back with start held high.
    word = 4'b0001; dir = 1'b0; fill = 1'b0; start = 1'b1;
    tick();
    chk("b2b first load", {s1, s0}, 2'b11);
    chk("b2b first I_par", I_par, 4'b0001);
    word = 4'b1000;
    shift_phase("b2b s1", 2'b01, 4'b1000);
    gap = 4;
    while (!({s1, s0} == 2'b11) && gap < 20) begin
      tick();
      gap++;
    end
    chk("b2b load gap", gap, 7);
    chk("b2b second I_par", I_par, 4'b1000);
    start = 1'b0;
    shift_phase("b2b s2", 2'b01, 4'b0001);
    done_phase("b2b s2", 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
